// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: register-file geometry, special register
// indices and the architectural word type.
package mips_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
  localparam logic [REG_ADDR_W-1:0] REG_RA   = 5'd31;

  typedef logic [31:0] word_t;

endpackage

// File: rtl/reg_read_port.sv
// One combinational register-file read port: zero-index force plus an
// optional write-to-read bypass enabled by defining REGBANK_BYPASS_EN.
module reg_read_port
  import mips_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic              i_rst_n,
  input  logic [ADDR_W-1:0] i_rd_addr,
  input  logic [DATA_W-1:0] i_arr_data,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic [DATA_W-1:0] o_rd_data
);

  logic w_is_zero;
  assign w_is_zero = (i_rd_addr == ADDR_W'(REG_ZERO));

`ifdef REGBANK_BYPASS_EN
  // A write being committed on this edge is forwarded, unless reset discards it.
  logic w_bypass_hit;
  assign w_bypass_hit = i_rst_n && i_wr_en && (i_wr_addr != ADDR_W'(REG_ZERO))
                        && (i_wr_addr == i_rd_addr);

  always_comb begin
    o_rd_data = i_arr_data;
    if (w_bypass_hit) o_rd_data = i_wr_data;
    if (w_is_zero)    o_rd_data = '0;
  end
`else
  logic w_unused_bypass;
  assign w_unused_bypass = ^{i_rst_n, i_wr_en, i_wr_addr, i_wr_data};

  always_comb begin
    o_rd_data = i_arr_data;
    if (w_is_zero) o_rd_data = '0;
  end
`endif

endmodule

// File: rtl/register_bank.sv
// MIPS general-purpose register file: 32 x DATA_W, $zero hardwired, two
// combinational read ports. Optional same-cycle bypass via REGBANK_BYPASS_EN.
module register_bank
  import mips_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] writeReg,
  input  logic [DATA_W-1:0] writeData,
  input  logic [ADDR_W-1:0] readReg1,
  input  logic [ADDR_W-1:0] readReg2,
  output logic [DATA_W-1:0] readData1,
  output logic [DATA_W-1:0] readData2
);

  localparam int NREG = 1 << ADDR_W;

  logic [DATA_W-1:0] r_regs [0:NREG-1];

  // Entry 0 decodes to no write enable, so it stays at its reset value.
  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_reg
      logic w_wr_sel;
      assign w_wr_sel = RegWrite && (gi != 0) && (writeReg == ADDR_W'(gi));

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_regs[gi] <= '0;
        end else if (w_wr_sel) begin
          r_regs[gi] <= writeData;
        end
      end
    end
  endgenerate

  logic [DATA_W-1:0] w_arr_data1;
  logic [DATA_W-1:0] w_arr_data2;
  assign w_arr_data1 = r_regs[readReg1];
  assign w_arr_data2 = r_regs[readReg2];

  reg_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_port1 (
    .i_rst_n   (rst_n),
    .i_rd_addr (readReg1),
    .i_arr_data(w_arr_data1),
    .i_wr_en   (RegWrite),
    .i_wr_addr (writeReg),
    .i_wr_data (writeData),
    .o_rd_data (readData1)
  );

  reg_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_port2 (
    .i_rst_n   (rst_n),
    .i_rd_addr (readReg2),
    .i_arr_data(w_arr_data2),
    .i_wr_en   (RegWrite),
    .i_wr_addr (writeReg),
    .i_wr_data (writeData),
    .o_rd_data (readData2)
  );

endmodule
